calc1_req_sched: RTL and testbench
==================================

CALC1_REQ_SCHED -- requirements
Module: calc1_req_sched

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 64, ALU busy cycles before abort (used only with CALC1_SCHED_TIMEOUT_EN).
REQ-002 Port: c_clk  in  1  sole clock, rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high.
REQ-004 Port: reqN_cmd_in  in  4  command from requester N (N=1..4); 0 = none.
REQ-005 Port: reqN_data_in  in  32  operand 1 in the command cycle, operand 2 in the following cycle.
REQ-006 Port: out_respN  out  2  response to requester N; 0 = none, 1 = success, 2 = overflow/underflow/invalid.
REQ-007 Port: out_dataN  out  32  result to requester N; valid only when out_respN != 0.
REQ-008 Port: alu_valid_out  out  1  issue strobe to the shared ALU.
REQ-009 Port: alu_cmd_out, alu_op1_out, alu_op2_out, alu_tag_out  out  4/32/32/2  issued command, operands and port tag (0..3 = port 1..4).
REQ-010 Port: alu_done_in, alu_resp_in, alu_data_in, alu_tag_in  in  1/2/32/2  ALU completion strobe, response, result and echoed tag.

Function
REQ-011 Each port SHALL run the FSM IDLE -> OP2 -> PEND -> IDLE.
REQ-012 In IDLE, cmd != 0 at edge T SHALL latch cmd and op1; at T+1 op2 SHALL be latched and the FSM SHALL enter PEND.
REQ-013 Commands arriving while a port is not IDLE SHALL be ignored; each port has at most one outstanding command.
REQ-014 Valid commands are 1 add, 2 subtract, 5 shift left, 6 shift right; any other nonzero cmd SHALL produce out_respN=2 and out_dataN=0 in the cycle after op2 capture, without an ALU issue.
REQ-015 One ALU operation SHALL be outstanding at a time. alu_valid_out SHALL pulse for one cycle when the ALU is idle and at least one valid port is PEND.
REQ-016 Arbitration SHALL be round-robin. The pointer starts at port 1 after reset and advances to the port after the winner.
REQ-017 Earliest issue is T+2 relative to the command cycle.
REQ-018 On alu_done_in, out_respN/out_dataN of the tagged port SHALL carry alu_resp_in/alu_data_in for exactly one cycle, starting the cycle after done. The port SHALL return to IDLE and the ALU SHALL become free.
REQ-019 alu_done_in and a new issue in the same cycle SHALL both be honoured; the freed ALU may accept a new issue on the next cycle.
REQ-020 A port SHALL NOT accept a new command in the cycle its response is driven; it may accept one from the next cycle.
REQ-021 alu_done_in with a tag whose port is not PEND-issued SHALL be dropped.
REQ-022 All outputs not actively carrying a response or issue SHALL be 0.

Reset
REQ-023 Reset SHALL force all port FSMs to IDLE, clear the ALU-busy flag, return the arbitration pointer to port 1, and drive all outputs to 0 asynchronously.
REQ-024 Reset mid-operation SHALL discard all captured and in-flight commands; no response SHALL follow for them.

Configuration
REQ-025 With CALC1_SCHED_TIMEOUT_EN defined: if the ALU stays busy for TIMEOUT_CYCLES without alu_done_in, the tagged port SHALL get out_respN=2 and out_dataN=0, the ALU SHALL be freed, and a late done SHALL be dropped per REQ-021.
REQ-026 Without CALC1_SCHED_TIMEOUT_EN: no counter, and the block waits indefinitely for alu_done_in.

Structure
REQ-027 Package calc1_pkg SHALL hold the command encodings, response encodings, port FSM state enum, and tag type.
REQ-028 Per-port capture FSM SHALL be sub-module calc1_port_capture, instantiated 4 times; arbiter and response routing stay in calc1_req_sched.

Verification
REQ-029 Port 1 cmd=1, op1=0x0000001A, op2=0x00000005; ALU model returns resp=1 -> out_resp1=1, out_data1=0x0000001F, one cycle.
REQ-030 All four ports issue cmd=1 in the same cycle after reset -> alu_tag_out order 0,1,2,3; each port gets exactly one response.
REQ-031 Port 1 cmd=7, op1=0x2309ABEF, op2=0x332200FF -> out_resp1=2, out_data1=0, alu_valid_out never asserted.
REQ-032 Port 2 sends a second command while PEND -> it is ignored; exactly one response follows.
REQ-033 Reset asserted while port 3's add is at the ALU -> all outputs 0 immediately; the late alu_done_in with tag 2 produces no response.
REQ-034 With CALC1_SCHED_TIMEOUT_EN, the ALU model never completes -> out_resp4=2 after 64 busy cycles; the next pending port is then issued.

Source files
------------

// File: rtl/calc1_pkg.sv
// calc1_pkg: shared types for the calc1 request scheduler.
//   - command / response encodings
//   - per-port capture FSM state
//   - port tag type (0..3 = requester 1..4) and captured-request struct
//   - cmd_is_valid(): commands the shared ALU can execute
package calc1_pkg;

  localparam int NUM_PORTS = 4;
  localparam int DATA_W    = 32;

  typedef logic [1:0] tag_t;

  typedef enum logic [3:0] {
    CMD_NONE = 4'd0,
    CMD_ADD  = 4'd1,
    CMD_SUB  = 4'd2,
    CMD_SHL  = 4'd5,
    CMD_SHR  = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_ERR  = 2'd2
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OP2  = 2'd1,
    ST_PEND = 2'd2
  } port_state_e;

  typedef struct packed {
    logic [3:0]        cmd;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
  } req_t;

  function automatic logic cmd_is_valid(input logic [3:0] cmd);
    case (cmd)
      CMD_ADD, CMD_SUB, CMD_SHL, CMD_SHR: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/calc1_port_capture.sv
// calc1_port_capture: per-requester command capture FSM (IDLE -> OP2 -> PEND -> IDLE).
// Ports:
//   c_clk, reset  - clock, async active-high reset
//   cmd_i, data_i - requester command / operand bus
//   blk_i         - response being driven this cycle; hold off a new command
//   issue_i       - scheduler granted this port to the ALU (only while PEND)
//   release_i     - request finished (ALU done, timeout or rejected command)
//   state_o       - current FSM state
//   issued_o      - request is in flight at the ALU
//   req_o         - captured command and operands
module calc1_port_capture
  import calc1_pkg::*;
(
  input  logic              c_clk,
  input  logic              reset,
  input  logic [3:0]        cmd_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              blk_i,
  input  logic              issue_i,
  input  logic              release_i,
  output port_state_e       state_o,
  output logic              issued_o,
  output req_t              req_o
);

  port_state_e state_q;
  logic        issued_q;
  req_t        req_q;

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      issued_q <= 1'b0;
      req_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_i != '0 && !blk_i) begin
            req_q.cmd <= cmd_i;
            req_q.op1 <= data_i;
            state_q   <= ST_OP2;
          end
        end
        ST_OP2: begin
          req_q.op2 <= data_i;
          state_q   <= ST_PEND;
        end
        ST_PEND: begin
          // commands arriving here are ignored: one outstanding per port
          if (issue_i) issued_q <= 1'b1;
          if (release_i) begin
            state_q  <= ST_IDLE;
            issued_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign state_o  = state_q;
  assign issued_o = issued_q;
  assign req_o    = req_q;

endmodule

// File: rtl/calc1_req_sched.sv
// calc1_req_sched: four requesters share one ALU, round-robin, one op in flight.
// Ports:
//   c_clk, reset                      - clock, async active-high reset
//   reqN_cmd_in / reqN_data_in        - requester N command, op1 then op2 on data
//   out_respN / out_dataN             - one-cycle response to requester N
//   alu_valid_out, alu_cmd/op1/op2/tag_out - one-cycle issue to the ALU
//   alu_done_in, alu_resp/data/tag_in - ALU completion with echoed tag
// Optional: define CALC1_SCHED_TIMEOUT_EN to abort an ALU op after
// TIMEOUT_CYCLES busy cycles with an error response.
module calc1_req_sched
  import calc1_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [3:0]  req1_cmd_in,
  input  logic [3:0]  req2_cmd_in,
  input  logic [3:0]  req3_cmd_in,
  input  logic [3:0]  req4_cmd_in,
  input  logic [31:0] req1_data_in,
  input  logic [31:0] req2_data_in,
  input  logic [31:0] req3_data_in,
  input  logic [31:0] req4_data_in,
  output logic [1:0]  out_resp1,
  output logic [1:0]  out_resp2,
  output logic [1:0]  out_resp3,
  output logic [1:0]  out_resp4,
  output logic [31:0] out_data1,
  output logic [31:0] out_data2,
  output logic [31:0] out_data3,
  output logic [31:0] out_data4,
  output logic        alu_valid_out,
  output logic [3:0]  alu_cmd_out,
  output logic [31:0] alu_op1_out,
  output logic [31:0] alu_op2_out,
  output logic [1:0]  alu_tag_out,
  input  logic        alu_done_in,
  input  logic [1:0]  alu_resp_in,
  input  logic [31:0] alu_data_in,
  input  logic [1:0]  alu_tag_in
);

  logic [NUM_PORTS-1:0][3:0]        cmd_in;
  logic [NUM_PORTS-1:0][DATA_W-1:0] data_in;
  assign cmd_in  = {req4_cmd_in, req3_cmd_in, req2_cmd_in, req1_cmd_in};
  assign data_in = {req4_data_in, req3_data_in, req2_data_in, req1_data_in};

  port_state_e           st [NUM_PORTS];
  logic [NUM_PORTS-1:0]  issued, elig, inv_rel, done_rel, tmo_rel, release_v, issue_oh;
  req_t [NUM_PORTS-1:0]  req;

  logic                  busy_q, busy_d;
  tag_t                  ptr_q, ptr_d;
  tag_t                  btag_q, btag_d;   // tag of the op currently at the ALU
  logic                  alu_vld_q, alu_vld_d;
  req_t                  alu_req_q, alu_req_d;
  tag_t                  alu_tag_q, alu_tag_d;
  logic [NUM_PORTS-1:0][1:0]        resp_q, resp_d;
  logic [NUM_PORTS-1:0][DATA_W-1:0] data_q, data_d;
  logic [NUM_PORTS-1:0]  rblk_q, rblk_d;   // response on the wire this cycle

  tag_t                  win, idx;
  logic                  win_found, issue, done_ok, tmo_fire;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    calc1_port_capture u_cap (
      .c_clk     (c_clk),
      .reset     (reset),
      .cmd_i     (cmd_in[g]),
      .data_i    (data_in[g]),
      .blk_i     (rblk_q[g]),
      .issue_i   (issue_oh[g]),
      .release_i (release_v[g]),
      .state_o   (st[g]),
      .issued_o  (issued[g]),
      .req_o     (req[g])
    );
    assign elig[g]    = (st[g] == ST_PEND) && !issued[g] && cmd_is_valid(req[g].cmd);
    // unsupported commands never reach the ALU; they are answered directly
    assign inv_rel[g] = (st[g] == ST_PEND) && !cmd_is_valid(req[g].cmd);
  end

  // round-robin search starting at the pointer
  always_comb begin
    win       = ptr_q;
    win_found = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = ptr_q + tag_t'(k);
      if (!win_found && elig[idx]) begin
        win       = idx;
        win_found = 1'b1;
      end
    end
  end

  assign issue    = !busy_q && win_found;
  assign issue_oh = issue ? (NUM_PORTS'(1) << win) : '0;
  // a done whose tag is not the in-flight port is stale and dropped
  assign done_ok  = alu_done_in && busy_q && issued[alu_tag_in];
  assign done_rel = done_ok ? (NUM_PORTS'(1) << alu_tag_in) : '0;
  assign tmo_rel  = tmo_fire ? (NUM_PORTS'(1) << btag_q) : '0;
  assign release_v = done_rel | tmo_rel | inv_rel;

`ifdef CALC1_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q;

  // counts edges since issue; fires on the TIMEOUT_CYCLES-th busy edge
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset)        tmo_cnt_q <= '0;
    else if (!busy_q) tmo_cnt_q <= '0;
    else              tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
  end

  assign tmo_fire = busy_q && !done_ok && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // parameter kept so both builds share one instantiation
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
  assign tmo_fire       = 1'b0;
`endif

  always_comb begin
    busy_d    = busy_q;
    ptr_d     = ptr_q;
    btag_d    = btag_q;
    alu_vld_d = 1'b0;
    alu_req_d = '0;
    alu_tag_d = '0;
    // issue needs an idle ALU and done/timeout need a busy one, so never both
    if (issue) begin
      busy_d    = 1'b1;
      ptr_d     = win + tag_t'(1);
      btag_d    = win;
      alu_vld_d = 1'b1;
      alu_req_d = req[win];
      alu_tag_d = win;
    end else if (done_ok || tmo_fire) begin
      busy_d = 1'b0;
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      resp_d[p] = RESP_NONE;
      data_d[p] = '0;
      if (done_rel[p]) begin
        resp_d[p] = alu_resp_in;
        data_d[p] = alu_data_in;
      end else if (tmo_rel[p] || inv_rel[p]) begin
        resp_d[p] = RESP_ERR;
      end
    end
    rblk_d = release_v;
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      busy_q    <= 1'b0;
      ptr_q     <= '0;
      btag_q    <= '0;
      alu_vld_q <= 1'b0;
      alu_req_q <= '0;
      alu_tag_q <= '0;
      resp_q    <= '0;
      data_q    <= '0;
      rblk_q    <= '0;
    end else begin
      busy_q    <= busy_d;
      ptr_q     <= ptr_d;
      btag_q    <= btag_d;
      alu_vld_q <= alu_vld_d;
      alu_req_q <= alu_req_d;
      alu_tag_q <= alu_tag_d;
      resp_q    <= resp_d;
      data_q    <= data_d;
      rblk_q    <= rblk_d;
    end
  end

  assign alu_valid_out = alu_vld_q;
  assign alu_cmd_out   = alu_req_q.cmd;
  assign alu_op1_out   = alu_req_q.op1;
  assign alu_op2_out   = alu_req_q.op2;
  assign alu_tag_out   = alu_tag_q;
  assign out_resp1     = resp_q[0];
  assign out_resp2     = resp_q[1];
  assign out_resp3     = resp_q[2];
  assign out_resp4     = resp_q[3];
  assign out_data1     = data_q[0];
  assign out_data2     = data_q[1];
  assign out_data3     = data_q[2];
  assign out_data4     = data_q[3];

endmodule

// File: tb/tb_calc1_req_sched.sv
// tb_calc1_req_sched: randomized + directed bench for calc1_req_sched.
// The bench plays the ALU and keeps a timestamp-based reference of each
// port's outstanding command; outputs are compared every cycle.
module tb_calc1_req_sched;
  localparam int TMO = 64;
  typedef logic [143:0] cv_t;

  logic        c_clk = 1'b0;
  logic        rst;
  logic [3:0]  cmd_v  [4];
  logic [31:0] data_v [4];
  logic        alu_done_v;
  logic [1:0]  alu_resp_v, alu_tag_v;
  logic [31:0] alu_data_v;
  logic [1:0]  o_resp [4];
  logic [31:0] o_data [4];
  logic        alu_valid_o;
  logic [3:0]  alu_cmd_o;
  logic [31:0] alu_op1_o, alu_op2_o;
  logic [1:0]  alu_tag_o;

  always #5 c_clk = ~c_clk;

  calc1_req_sched #(.TIMEOUT_CYCLES(TMO)) dut (
    .c_clk(c_clk), .reset(rst),
    .req1_cmd_in(cmd_v[0]), .req2_cmd_in(cmd_v[1]), .req3_cmd_in(cmd_v[2]), .req4_cmd_in(cmd_v[3]),
    .req1_data_in(data_v[0]), .req2_data_in(data_v[1]), .req3_data_in(data_v[2]), .req4_data_in(data_v[3]),
    .out_resp1(o_resp[0]), .out_resp2(o_resp[1]), .out_resp3(o_resp[2]), .out_resp4(o_resp[3]),
    .out_data1(o_data[0]), .out_data2(o_data[1]), .out_data3(o_data[2]), .out_data4(o_data[3]),
    .alu_valid_out(alu_valid_o), .alu_cmd_out(alu_cmd_o), .alu_op1_out(alu_op1_o),
    .alu_op2_out(alu_op2_o), .alu_tag_out(alu_tag_o),
    .alu_done_in(alu_done_v), .alu_resp_in(alu_resp_v), .alu_data_in(alu_data_v), .alu_tag_in(alu_tag_v)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input cv_t got, input cv_t exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          cyc = 0;
  bit          m_pend [4], m_iss [4];
  logic [3:0]  m_cmd  [4];
  logic [31:0] m_op1  [4], m_op2 [4];
  int          m_cap  [4], m_free [4];
  bit          m_busy;
  logic [1:0]  m_tag;
  int          m_ptr, m_iss_edge;
  logic [1:0]  e_resp [4];
  logic [31:0] e_data [4];
  bit          e_vld;
  logic [3:0]  e_cmd;
  logic [31:0] e_op1, e_op2;
  logic [1:0]  e_tag;

  function automatic bit is_valid(input logic [3:0] c);
    return (c == 4'd1) || (c == 4'd2) || (c == 4'd5) || (c == 4'd6);
  endfunction

  task automatic model_step();
    bit old_busy, found;
    int q;
    e_vld = 0; e_cmd = '0; e_op1 = '0; e_op2 = '0; e_tag = '0;
    for (int p = 0; p < 4; p++) begin e_resp[p] = '0; e_data[p] = '0; end
    if (rst) begin
      for (int p = 0; p < 4; p++) begin m_pend[p] = 0; m_iss[p] = 0; m_free[p] = 0; end
      m_busy = 0; m_ptr = 0;
      return;
    end
    old_busy = m_busy;
    for (int p = 0; p < 4; p++)
      if (m_pend[p] && m_cap[p] == cyc - 1) m_op2[p] = data_v[p];
    if (alu_done_v && m_busy && alu_tag_v == m_tag) begin
      e_resp[m_tag] = alu_resp_v; e_data[m_tag] = alu_data_v;
      m_pend[m_tag] = 0; m_iss[m_tag] = 0; m_free[m_tag] = cyc + 2; m_busy = 0;
    end
`ifdef CALC1_SCHED_TIMEOUT_EN
    else if (m_busy && cyc - m_iss_edge == TMO) begin
      e_resp[m_tag] = 2'd2;
      m_pend[m_tag] = 0; m_iss[m_tag] = 0; m_free[m_tag] = cyc + 2; m_busy = 0;
    end
`endif
    for (int p = 0; p < 4; p++)
      if (m_pend[p] && cyc >= m_cap[p] + 2 && !is_valid(m_cmd[p])) begin
        e_resp[p] = 2'd2; m_pend[p] = 0; m_free[p] = cyc + 2;
      end
    if (!old_busy) begin
      found = 0;
      for (int k = 0; k < 4; k++) begin
        q = (m_ptr + k) % 4;
        if (!found && m_pend[q] && !m_iss[q] && cyc >= m_cap[q] + 2 && is_valid(m_cmd[q])) begin
          found = 1;
          e_vld = 1; e_cmd = m_cmd[q]; e_op1 = m_op1[q]; e_op2 = m_op2[q]; e_tag = 2'(q);
          m_iss[q] = 1; m_busy = 1; m_tag = 2'(q); m_iss_edge = cyc; m_ptr = (q + 1) % 4;
        end
      end
    end
    for (int p = 0; p < 4; p++)
      if (cmd_v[p] != 0 && !m_pend[p] && cyc >= m_free[p]) begin
        m_pend[p] = 1; m_iss[p] = 0; m_cmd[p] = cmd_v[p]; m_op1[p] = data_v[p]; m_cap[p] = cyc;
      end
  endtask

  // ---------------- ALU model / environment ----------------
  int          due = -1, alu_lat = 0;
  bit          hang = 0, spur_en = 0;
  logic [1:0]  due_tag, due_resp;
  logic [31:0] due_data;

  task automatic alu_accept();
    logic [32:0] s;
    if (!e_vld) return;
    case (e_cmd)
      4'd1: begin s = {1'b0, e_op1} + {1'b0, e_op2}; due_data = s[31:0]; due_resp = s[32] ? 2'd2 : 2'd1; end
      4'd2: begin due_data = e_op1 - e_op2; due_resp = (e_op1 < e_op2) ? 2'd2 : 2'd1; end
      4'd5: begin due_data = e_op1 << e_op2[4:0]; due_resp = 2'd1; end
      default: begin due_data = e_op1 >> e_op2[4:0]; due_resp = 2'd1; end
    endcase
    due_tag = e_tag;
    if (hang) hang = 0;
    else due = cyc + ((alu_lat > 0) ? alu_lat : int'($urandom_range(1, 6)));
  endtask

  task automatic drive_env();
    for (int p = 0; p < 4; p++) begin cmd_v[p] = '0; data_v[p] = $urandom; end
    alu_done_v = 0; alu_resp_v = 2'($urandom); alu_data_v = $urandom; alu_tag_v = 2'($urandom);
    if (due == cyc + 1) begin
      alu_done_v = 1; alu_tag_v = due_tag; alu_resp_v = due_resp; alu_data_v = due_data; due = -1;
    end else if (spur_en && $urandom_range(0, 5) == 0) begin
      alu_done_v = 1;
      alu_tag_v  = m_busy ? (m_tag ^ 2'($urandom_range(1, 3))) : 2'($urandom_range(0, 3));
    end
  endtask

  // ---------------- monitor ----------------
  int          rsp_cnt [4], rsp_cyc [4];
  logic [1:0]  last_resp [4];
  logic [31:0] last_data [4];
  logic [1:0]  iss_log [$];
  int          iss_cyc [$];

  task automatic clear_mon();
    for (int p = 0; p < 4; p++) rsp_cnt[p] = 0;
    iss_log.delete(); iss_cyc.delete();
  endtask

  task automatic tick();
    @(posedge c_clk);
    cyc++;
    model_step();
    alu_accept();
    @(negedge c_clk);
    chk("alu", cv_t'({alu_valid_o, alu_cmd_o, alu_op1_o, alu_op2_o, alu_tag_o}),
               cv_t'({e_vld, e_cmd, e_op1, e_op2, e_tag}));
    chk("rsp", cv_t'({o_resp[3], o_resp[2], o_resp[1], o_resp[0], o_data[3], o_data[2], o_data[1], o_data[0]}),
               cv_t'({e_resp[3], e_resp[2], e_resp[1], e_resp[0], e_data[3], e_data[2], e_data[1], e_data[0]}));
    if (alu_valid_o) begin iss_log.push_back(alu_tag_o); iss_cyc.push_back(cyc); end
    for (int p = 0; p < 4; p++)
      if (o_resp[p] != 0) begin
        rsp_cnt[p]++; rsp_cyc[p] = cyc; last_resp[p] = o_resp[p]; last_data[p] = o_data[p];
      end
    drive_env();
  endtask

  task automatic do_reset();
    rst = 1; tick(); tick(); rst = 0;
    due = -1; hang = 0; clear_mon();
  endtask

  function automatic cv_t all_out();
    return cv_t'({alu_valid_o, alu_cmd_o, alu_op1_o, alu_op2_o, alu_tag_o,
                  o_resp[0], o_resp[1], o_resp[2], o_resp[3]}) |
           cv_t'({o_data[0], o_data[1], o_data[2], o_data[3]});
  endfunction

  logic [7:0] ord;
  logic [3:0] rc;

  initial begin
    rst = 1;
    for (int p = 0; p < 4; p++) begin cmd_v[p] = '0; data_v[p] = '0; end
    alu_done_v = 0; alu_resp_v = '0; alu_data_v = '0; alu_tag_v = '0;
    do_reset();
    chk("reset_out", all_out(), '0);

    // add 0x1A + 0x05 on port 1
    alu_lat = 2;
    cmd_v[0] = 4'd1; data_v[0] = 32'h0000001A; tick();
    data_v[0] = 32'h00000005; tick();
    for (int i = 0; i < 20 && rsp_cnt[0] == 0; i++) tick();
    chk("r29_seen", cv_t'(rsp_cnt[0]), cv_t'(1));
    chk("r29_resp", cv_t'(last_resp[0]), cv_t'(2'd1));
    chk("r29_data", cv_t'(last_data[0]), cv_t'(32'h1F));
    tick(); tick();
    chk("r29_once", cv_t'(rsp_cnt[0]), cv_t'(1));

    // all four ports at once: issue order 0,1,2,3
    do_reset(); alu_lat = 0;
    for (int p = 0; p < 4; p++) cmd_v[p] = 4'd1;
    tick(); tick();
    for (int i = 0; i < 40; i++) tick();
    ord = '0;
    for (int i = 0; i < iss_log.size() && i < 4; i++) ord[7-2*i -: 2] = iss_log[i];
    chk("r30_nissue", cv_t'(iss_log.size()), cv_t'(4));
    chk("r30_order", cv_t'(ord), cv_t'(8'h1B));
    for (int p = 0; p < 4; p++) chk("r30_rsp", cv_t'(rsp_cnt[p]), cv_t'(1));

    // unsupported command on port 1
    do_reset();
    cmd_v[0] = 4'd7; data_v[0] = 32'h2309ABEF; tick();
    data_v[0] = 32'h332200FF; tick();
    for (int i = 0; i < 8; i++) tick();
    chk("r31_noissue", cv_t'(iss_log.size()), cv_t'(0));
    chk("r31_cnt", cv_t'(rsp_cnt[0]), cv_t'(1));
    chk("r31_resp", cv_t'(last_resp[0]), cv_t'(2'd2));
    chk("r31_data", cv_t'(last_data[0]), cv_t'(0));

    // second command on port 2 while pending is ignored
    do_reset(); alu_lat = 8;
    cmd_v[1] = 4'd2; tick(); tick(); tick();
    cmd_v[1] = 4'd1; tick(); tick();
    for (int i = 0; i < 20; i++) tick();
    chk("r32_cnt", cv_t'(rsp_cnt[1]), cv_t'(1));
    chk("r32_issue", cv_t'(iss_log.size()), cv_t'(1));

    // reset while port 3's add is at the ALU; its late done must be dropped
    do_reset(); alu_lat = 12;
    cmd_v[2] = 4'd1; tick(); tick(); tick(); tick();
    chk("r33_busy", cv_t'(iss_log.size()), cv_t'(1));
    rst = 1; #1;
    chk("r33_async", all_out(), '0);
    tick(); tick(); rst = 0; clear_mon();
    for (int i = 0; i < 20; i++) tick();
    rc = {rsp_cnt[3] != 0, rsp_cnt[2] != 0, rsp_cnt[1] != 0, rsp_cnt[0] != 0};
    chk("r33_norsp", cv_t'(rc), '0);

`ifdef CALC1_SCHED_TIMEOUT_EN
    // ALU never answers port 4; port 1 waits behind it
    do_reset(); alu_lat = 3; hang = 1;
    cmd_v[3] = 4'd1; tick(); tick();
    cmd_v[0] = 4'd1; tick();
    for (int i = 0; i < 150 && rsp_cnt[3] == 0; i++) tick();
    chk("r34_resp", cv_t'(last_resp[3]), cv_t'(2'd2));
    chk("r34_data", cv_t'(last_data[3]), cv_t'(0));
    chk("r34_lat", cv_t'(rsp_cyc[3] - ((iss_cyc.size() > 0) ? iss_cyc[0] : 0)), cv_t'(TMO));
    for (int i = 0; i < 15; i++) tick();
    chk("r34_next_n", cv_t'(iss_log.size()), cv_t'(2));
    if (iss_log.size() >= 2) begin
      chk("r34_next_tag", cv_t'(iss_log[1]), cv_t'(2'd0));
      chk("r34_next_cyc", cv_t'(iss_cyc[1] - rsp_cyc[3]), cv_t'(1));
    end
`endif

    // randomized traffic with stray done strobes and one mid-run reset
    do_reset(); alu_lat = 0; spur_en = 1;
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) rst = 1;
      if (i == 701) rst = 0;
      for (int p = 0; p < 4; p++)
        if ($urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 5))
            0: cmd_v[p] = 4'd1;
            1: cmd_v[p] = 4'd2;
            2: cmd_v[p] = 4'd5;
            3: cmd_v[p] = 4'd6;
            default: cmd_v[p] = 4'($urandom_range(1, 15));
          endcase
        end
      tick();
    end
    spur_en = 0;
    for (int i = 0; i < 20; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
